// File: rtl/chan_fifo_array.sv
// Array of CHAN_NUM independent FIFOs sharing one write port and one read port.
// Optional sticky overflow/underflow flags are enabled by defining CHAN_FIFO_ERR_STATUS_EN.
module chan_fifo_array #(
  parameter int DATA_WIDTH      = 32,
  parameter int OSTD_NUM        = 8,
  parameter int CHAN_NUM        = 4,
  parameter int THRESHOLD_VALUE = OSTD_NUM / 2,
  parameter int PTR_SIZE        = $clog2(OSTD_NUM),
  parameter int CHAN_SIZE       = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1,
  parameter int CNT_SIZE        = PTR_SIZE + 1
) (
  input  logic                  clk_in,
  input  logic                  sreset,
  input  logic                  wr_valid,
  input  logic [CHAN_SIZE-1:0]  wr_chan,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_valid,
  input  logic [CHAN_SIZE-1:0]  rd_chan,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic [CHAN_NUM-1:0]   chan_empty,
  output logic [CHAN_NUM-1:0]   chan_full,
  output logic [CHAN_NUM-1:0]   chan_afull,
  output logic [CHAN_NUM-1:0]   chan_err_ovf,
  output logic [CHAN_NUM-1:0]   chan_err_udf,
  input  logic                  err_clr
);

  localparam logic [CHAN_SIZE:0]  CHAN_LIMIT = (CHAN_SIZE + 1)'(CHAN_NUM);
  localparam logic [CNT_SIZE-1:0] FULL_CNT   = CNT_SIZE'(OSTD_NUM);
  localparam logic [CNT_SIZE-1:0] AFULL_CNT  = CNT_SIZE'(THRESHOLD_VALUE);

  logic [DATA_WIDTH-1:0] mem [CHAN_NUM][OSTD_NUM];
  logic [PTR_SIZE-1:0]   wptr    [CHAN_NUM];
  logic [PTR_SIZE-1:0]   rptr    [CHAN_NUM];
  logic [CNT_SIZE-1:0]   cnt     [CHAN_NUM];
  logic [CNT_SIZE-1:0]   cnt_nxt [CHAN_NUM];

  logic                wr_chan_ok, rd_chan_ok;
  logic [CNT_SIZE-1:0] wr_cnt, rd_cnt;
  logic [PTR_SIZE-1:0] wr_ptr_sel, rd_ptr_sel;
  logic                wr_acc, rd_acc;
  logic [CHAN_NUM-1:0] wr_hit, rd_hit;

  assign wr_chan_ok = {1'b0, wr_chan} < CHAN_LIMIT;
  assign rd_chan_ok = {1'b0, rd_chan} < CHAN_LIMIT;

  // Per-port channel muxes; out-of-range channels select nothing and read as empty/zero.
  always_comb begin
    wr_cnt     = '0;
    rd_cnt     = '0;
    wr_ptr_sel = '0;
    rd_ptr_sel = '0;
    for (int c = 0; c < CHAN_NUM; c++) begin
      if (wr_chan_ok && wr_chan == CHAN_SIZE'(c)) begin
        wr_cnt     = cnt[c];
        wr_ptr_sel = wptr[c];
      end
      if (rd_chan_ok && rd_chan == CHAN_SIZE'(c)) begin
        rd_cnt     = cnt[c];
        rd_ptr_sel = rptr[c];
      end
    end
  end

  // A full channel still accepts a write when the same cycle pops it.
  assign rd_acc   = rd_valid && rd_chan_ok && (rd_cnt != '0);
  assign wr_ready = wr_chan_ok &&
                    ((wr_cnt < FULL_CNT) || (rd_acc && (rd_chan == wr_chan)));
  assign wr_acc   = wr_valid && wr_ready;

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int c = 0; c < CHAN_NUM; c++) begin
      wr_hit[c]  = wr_acc && (wr_chan == CHAN_SIZE'(c));
      rd_hit[c]  = rd_acc && (rd_chan == CHAN_SIZE'(c));
      cnt_nxt[c] = cnt[c];
      if (wr_hit[c] && !rd_hit[c])
        cnt_nxt[c] = cnt[c] + CNT_SIZE'(1);
      else if (rd_hit[c] && !wr_hit[c])
        cnt_nxt[c] = cnt[c] - CNT_SIZE'(1);
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_in) begin
    if (!sreset && wr_acc)
      mem[wr_chan][wr_ptr_sel] <= wr_data;
  end

  always_ff @(posedge clk_in) begin
    if (sreset) begin
      for (int c = 0; c < CHAN_NUM; c++) begin
        cnt[c]  <= '0;
        wptr[c] <= '0;
        rptr[c] <= '0;
      end
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      chan_empty    <= '1;
      chan_full     <= '0;
      chan_afull    <= {CHAN_NUM{THRESHOLD_VALUE == 0}};
    end else begin
      for (int c = 0; c < CHAN_NUM; c++) begin
        cnt[c] <= cnt_nxt[c];
        if (wr_hit[c])
          wptr[c] <= wptr[c] + PTR_SIZE'(1);
        if (rd_hit[c])
          rptr[c] <= rptr[c] + PTR_SIZE'(1);
        chan_empty[c] <= (cnt_nxt[c] == '0);
        chan_full[c]  <= (cnt_nxt[c] == FULL_CNT);
        chan_afull[c] <= (cnt_nxt[c] >= AFULL_CNT);
      end
      rd_data_valid <= rd_acc;
      if (rd_acc)
        rd_data <= mem[rd_chan][rd_ptr_sel];
    end
  end

`ifdef CHAN_FIFO_ERR_STATUS_EN
  logic [CHAN_NUM-1:0] ovf_set, udf_set, ovf_q, udf_q;

  always_comb begin
    ovf_set = '0;
    udf_set = '0;
    for (int c = 0; c < CHAN_NUM; c++) begin
      ovf_set[c] = wr_valid && !wr_ready && wr_chan_ok && (wr_chan == CHAN_SIZE'(c));
      udf_set[c] = rd_valid && rd_chan_ok && (rd_chan == CHAN_SIZE'(c)) && (rd_cnt == '0);
    end
  end

  // Sticky flags: a new event in the clearing cycle keeps its flag set.
  always_ff @(posedge clk_in) begin
    if (sreset) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      ovf_q <= ovf_set | (err_clr ? '0 : ovf_q);
      udf_q <= udf_set | (err_clr ? '0 : udf_q);
    end
  end

  assign chan_err_ovf = ovf_q;
  assign chan_err_udf = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign chan_err_ovf   = '0;
  assign chan_err_udf   = '0;
`endif

endmodule

// File: tb/tb_chan_fifo_array.sv
// Directed self-checking bench for chan_fifo_array at default parameters.
// Error-flag expectations follow whether CHAN_FIFO_ERR_STATUS_EN is defined.
module tb_chan_fifo_array;

`ifdef CHAN_FIFO_ERR_STATUS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        sreset;
  logic        wr_valid;
  logic [1:0]  wr_chan;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [1:0]  rd_chan;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic [3:0]  chan_empty, chan_full, chan_afull, chan_err_ovf, chan_err_udf;
  logic        err_clr;

  int num_checks = 0;
  int num_fails  = 0;

  logic [31:0] q0[$];
  logic [31:0] q3[$];

  chan_fifo_array dut (
    .clk_in        (clk_in),
    .sreset        (sreset),
    .wr_valid      (wr_valid),
    .wr_chan       (wr_chan),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .rd_valid      (rd_valid),
    .rd_chan       (rd_chan),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .chan_empty    (chan_empty),
    .chan_full     (chan_full),
    .chan_afull    (chan_afull),
    .chan_err_ovf  (chan_err_ovf),
    .chan_err_udf  (chan_err_udf),
    .err_clr       (err_clr)
  );

  always #5 clk_in = ~clk_in;

  // Advance one rising edge, then sample 1 ns later.
  task automatic applyStimulus();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    assert (observed === expected)
    else begin
      num_fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idleInputs();
    wr_valid = 1'b0;
    wr_chan  = 2'd0;
    wr_data  = 32'h0;
    rd_valid = 1'b0;
    rd_chan  = 2'd0;
    err_clr  = 1'b0;
  endtask

  initial begin
    logic        rd_ok;
    logic [31:0] exp_data;
    logic [31:0] last_data;

    // Reset
    idleInputs();
    sreset = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_rd_data", rd_data, 32'h0);
    checkOutput("rst_rd_valid", {31'b0, rd_data_valid}, 32'h0);
    checkOutput("rst_empty", {28'b0, chan_empty}, 32'hF);
    checkOutput("rst_full", {28'b0, chan_full}, 32'h0);
    checkOutput("rst_afull", {28'b0, chan_afull}, 32'h0);
    checkOutput("rst_ovf", {28'b0, chan_err_ovf}, 32'h0);
    checkOutput("rst_udf", {28'b0, chan_err_udf}, 32'h0);
    sreset = 1'b0;

    // Fill ch0 with 8 entries
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_chan  = 2'd0;
      wr_data  = 32'hA5A5_0001 + i;
      #1;
      checkOutput($sformatf("ch0_wr_ready_%0d", i), {31'b0, wr_ready}, 32'h1);
      applyStimulus();
      checkOutput($sformatf("ch0_afull_%0d", i), {31'b0, chan_afull[0]}, {31'b0, i >= 3});
      checkOutput($sformatf("ch0_full_%0d", i), {31'b0, chan_full[0]}, {31'b0, i == 7});
    end
    #1;
    checkOutput("ch0_full_wr_ready", {31'b0, wr_ready}, 32'h0);
    idleInputs();

    // Drain ch0 in order, data one cycle after each request
    for (int i = 0; i < 8; i++) begin
      rd_valid = 1'b1;
      rd_chan  = 2'd0;
      applyStimulus();
      checkOutput($sformatf("ch0_rd_valid_%0d", i), {31'b0, rd_data_valid}, 32'h1);
      checkOutput($sformatf("ch0_rd_data_%0d", i), rd_data, 32'hA5A5_0001 + i);
      checkOutput($sformatf("ch0_empty_%0d", i), {31'b0, chan_empty[0]}, {31'b0, i == 7});
    end
    idleInputs();
    applyStimulus();
    checkOutput("ch0_idle_rd_valid", {31'b0, rd_data_valid}, 32'h0);

    // Fill ch1, then attempt an overflow write
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_chan  = 2'd1;
      wr_data  = 32'h0000_1000 + i;
      applyStimulus();
    end
    checkOutput("ch1_full", {28'b0, chan_full}, 32'h2);
    wr_data = 32'hDEAD_BEEF;
    #1;
    checkOutput("ch1_ovf_wr_ready", {31'b0, wr_ready}, 32'h0);
    applyStimulus();
    checkOutput("ch1_ovf_flag", {28'b0, chan_err_ovf}, ERR_EN ? 32'h2 : 32'h0);
    checkOutput("ch1_still_full", {28'b0, chan_full}, 32'h2);

    // Simultaneous write and read on full ch1
    wr_data  = 32'h0000_2000;
    rd_valid = 1'b1;
    rd_chan  = 2'd1;
    #1;
    checkOutput("ch1_wr_rd_ready", {31'b0, wr_ready}, 32'h1);
    applyStimulus();
    checkOutput("ch1_wr_rd_valid", {31'b0, rd_data_valid}, 32'h1);
    checkOutput("ch1_wr_rd_data", rd_data, 32'h0000_1000);
    checkOutput("ch1_wr_rd_full", {28'b0, chan_full}, 32'h2);
    wr_valid = 1'b0;

    // Drain ch1: the dropped overflow word must not appear
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      exp_data = (i < 7) ? 32'h0000_1001 + i : 32'h0000_2000;
      checkOutput($sformatf("ch1_drain_%0d", i), rd_data, exp_data);
    end
    checkOutput("ch1_empty", {31'b0, chan_empty[1]}, 32'h1);

    // Read of empty ch2, then clear errors
    rd_chan = 2'd2;
    applyStimulus();
    checkOutput("ch2_udf_rd_valid", {31'b0, rd_data_valid}, 32'h0);
    checkOutput("ch2_udf_rd_data", rd_data, 32'h0000_2000);
    checkOutput("ch2_udf_flag", {28'b0, chan_err_udf}, ERR_EN ? 32'h4 : 32'h0);
    checkOutput("ovf_sticky", {28'b0, chan_err_ovf}, ERR_EN ? 32'h2 : 32'h0);
    idleInputs();
    err_clr = 1'b1;
    applyStimulus();
    err_clr = 1'b0;
    checkOutput("clr_udf", {28'b0, chan_err_udf}, 32'h0);
    checkOutput("clr_ovf", {28'b0, chan_err_ovf}, 32'h0);

    // Interleave ch0/ch3 writes with continuous ch3 reads
    last_data = rd_data;
    for (int k = 0; k < 24; k++) begin
      wr_valid = 1'b1;
      wr_chan  = (k % 4 == 3) ? 2'd0 : 2'd3;
      wr_data  = 32'hC000_0000 + k;
      rd_valid = 1'b1;
      rd_chan  = 2'd3;
      rd_ok    = (q3.size() != 0);
      exp_data = last_data;
      if (rd_ok) exp_data = q3.pop_front();
      if (wr_chan == 2'd0) q0.push_back(wr_data);
      else q3.push_back(wr_data);
      applyStimulus();
      checkOutput($sformatf("mix_rd_valid_%0d", k), {31'b0, rd_data_valid}, {31'b0, rd_ok});
      checkOutput($sformatf("mix_rd_data_%0d", k), rd_data, exp_data);
      last_data = exp_data;
    end
    idleInputs();
    for (int i = 0; i < 6; i++) begin
      rd_valid = 1'b1;
      rd_chan  = 2'd0;
      exp_data = q0.pop_front();
      applyStimulus();
      checkOutput($sformatf("mix_ch0_drain_%0d", i), rd_data, exp_data);
    end
    idleInputs();
    applyStimulus();
    checkOutput("mix_all_empty", {28'b0, chan_empty}, 32'hF);

    // Burst into ch0 (plus one word in ch2), then reset mid-burst
    wr_valid = 1'b1;
    wr_chan  = 2'd2;
    wr_data  = 32'h0000_0077;
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      wr_chan = 2'd0;
      wr_data = 32'hB000_0000 + i;
      applyStimulus();
      checkOutput($sformatf("burst_afull_%0d", i), {31'b0, chan_afull[0]}, {31'b0, i == 3});
    end
    wr_data  = 32'h0000_0099;
    rd_valid = 1'b1;
    rd_chan  = 2'd2;
    sreset   = 1'b1;
    applyStimulus();
    sreset = 1'b0;
    idleInputs();
    checkOutput("mid_rst_empty", {28'b0, chan_empty}, 32'hF);
    checkOutput("mid_rst_full", {28'b0, chan_full}, 32'h0);
    checkOutput("mid_rst_afull", {28'b0, chan_afull}, 32'h0);
    checkOutput("mid_rst_rd_valid", {31'b0, rd_data_valid}, 32'h0);
    checkOutput("mid_rst_rd_data", rd_data, 32'h0);
    rd_valid = 1'b1;
    rd_chan  = 2'd2;
    applyStimulus();
    checkOutput("post_rst_ch2_read", {31'b0, rd_data_valid}, 32'h0);
    rd_chan = 2'd0;
    applyStimulus();
    checkOutput("post_rst_ch0_read", {31'b0, rd_data_valid}, 32'h0);
    idleInputs();

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
